// File: rtl/measurement_pkg.sv
// Shared widths, FSM state encoding and the magnitude helper for quantum_measurement.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: not applicable.
package measurement_pkg;

    localparam int AMP_W = 16;
    localparam int MAG_W = 32;
    localparam int TOT_W = 34;
    localparam int NUM_W = 40;
    localparam int RES_W = 8;
    localparam int SCALE = 255;

    typedef enum logic [2:0] {
        ST_SAMPLE = 3'd0,
        ST_SUM    = 3'd1,
        ST_DIV0   = 3'd2,
        ST_DIV1   = 3'd3,
        ST_DIV2   = 3'd4,
        ST_DIV3   = 3'd5,
        ST_LOAD   = 3'd6
    } state_t;

    // |a|^2 = re^2 + im^2.  Each square is at most 2^30 (at -32768), so the
    // sum peaks at 2^31 and fits an unsigned 32-bit result.
    function automatic logic [MAG_W-1:0] cmag(input logic signed [AMP_W-1:0] re,
                                               input logic signed [AMP_W-1:0] im);
        logic signed [MAG_W-1:0] r2;
        logic signed [MAG_W-1:0] i2;
        r2 = MAG_W'(re) * MAG_W'(re);
        i2 = MAG_W'(im) * MAG_W'(im);
        return $unsigned(r2) + $unsigned(i2);
    endfunction

endpackage

// File: rtl/meas_div_r4.sv
// Radix-4 restoring divider: 40-bit numerator / 34-bit denominator -> 8-bit quotient.
// Latency: load cycle plus 4 step cycles (2 quotient bits per step, MSB first).
// Backpressure: none; driven by load/step strobes from the owning FSM.
//
// Ports: clk, reset (async, active-high); load captures num; step retires two
// quotient bits against den; quo is the quotient, forced to 0 while den == 0.
// The caller guarantees num < 256*den, so the initial partial remainder
// num[39:8] is already below den and every step yields a digit in 0..3.
module meas_div_r4
    import measurement_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [NUM_W-1:0] num,
    input  logic [TOT_W-1:0] den,
    output logic [RES_W-1:0] quo
);

    logic [TOT_W-1:0]   rem;
    logic [RES_W-1:0]   nlo;
    logic [RES_W-1:0]   q;

    logic [TOT_W+1:0]   t;
    logic [TOT_W+1:0]   d1;
    logic [TOT_W+1:0]   d2;
    logic [TOT_W+1:0]   d3;
    logic [1:0]         digit;
    logic [TOT_W-1:0]   rem_nxt;

    always_comb begin
        t  = {rem, nlo[RES_W-1 -: 2]};
        d1 = (TOT_W+2)'(den);
        d2 = d1 << 1;
        d3 = d1 + d2;
        digit   = 2'd0;
        rem_nxt = rem;
        // Restoring selection: largest multiple of den not exceeding t.
        if (t >= d3) begin
            digit   = 2'd3;
            rem_nxt = TOT_W'(t - d3);
        end else if (t >= d2) begin
            digit   = 2'd2;
            rem_nxt = TOT_W'(t - d2);
        end else if (t >= d1) begin
            digit   = 2'd1;
            rem_nxt = TOT_W'(t - d1);
        end else begin
            digit   = 2'd0;
            rem_nxt = TOT_W'(t);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            nlo <= '0;
            q   <= '0;
        end else if (load) begin
            rem <= TOT_W'(num[NUM_W-1:RES_W]);
            nlo <= num[RES_W-1:0];
            q   <= '0;
        end else if (step) begin
            rem <= rem_nxt;
            nlo <= {nlo[RES_W-3:0], 2'b00};
            q   <= {q[RES_W-3:0], digit};
        end
    end

    // All-zero amplitudes: the digit logic would select 3 every step, so the
    // guard pins the quotient to 0 instead.
    assign quo = (den == '0) ? '0 : q;

endmodule

// File: rtl/quantum_measurement.sv
// Two-qubit probability readout: result_k = floor(255*|a_k|^2 / sum|a_j|^2).
// Latency: 7-cycle free-running loop; results load 6 edges after the sampling edge.
// Backpressure: none; inputs sampled only in SAMPLE, results held between LOAD edges.
//
// Ports: clk, reset (async, active-high); ampXX_real/ampXX_imag signed 16-bit
// amplitudes of |00>,|01>,|10>,|11>; result0..3 registered 8-bit probabilities.
// Build option: define MEASUREMENT_ROUND_EN to add floor(total/2) to each
// numerator for round-to-nearest; undefined gives truncating division.
module quantum_measurement
    import measurement_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [AMP_W-1:0] amp00_real,
    input  logic signed [AMP_W-1:0] amp00_imag,
    input  logic signed [AMP_W-1:0] amp01_real,
    input  logic signed [AMP_W-1:0] amp01_imag,
    input  logic signed [AMP_W-1:0] amp10_real,
    input  logic signed [AMP_W-1:0] amp10_imag,
    input  logic signed [AMP_W-1:0] amp11_real,
    input  logic signed [AMP_W-1:0] amp11_imag,
    output logic [RES_W-1:0]        result0,
    output logic [RES_W-1:0]        result1,
    output logic [RES_W-1:0]        result2,
    output logic [RES_W-1:0]        result3
);

    state_t state, state_nxt;

    logic mag_en;
    logic ld_en;
    logic step_en;
    logic res_en;

    logic [3:0][MAG_W-1:0] mag;
    logic [TOT_W-1:0]      total;
    logic [TOT_W-1:0]      sum_c;
    logic [3:0][NUM_W-1:0] num_c;
    logic [3:0][RES_W-1:0] quo;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_SAMPLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = ST_SAMPLE;
        case (state)
            ST_SAMPLE: state_nxt = ST_SUM;
            ST_SUM:    state_nxt = ST_DIV0;
            ST_DIV0:   state_nxt = ST_DIV1;
            ST_DIV1:   state_nxt = ST_DIV2;
            ST_DIV2:   state_nxt = ST_DIV3;
            ST_DIV3:   state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_SAMPLE;
            default:   state_nxt = ST_SAMPLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mag_en  = 1'b0;
        ld_en   = 1'b0;
        step_en = 1'b0;
        res_en  = 1'b0;
        case (state)
            ST_SAMPLE: mag_en  = 1'b1;
            ST_SUM:    ld_en   = 1'b1;
            ST_DIV0,
            ST_DIV1,
            ST_DIV2,
            ST_DIV3:   step_en = 1'b1;
            ST_LOAD:   res_en  = 1'b1;
            default:   mag_en  = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        sum_c = TOT_W'(mag[0]) + TOT_W'(mag[1]) + TOT_W'(mag[2]) + TOT_W'(mag[3]);
        for (int k = 0; k < 4; k++) begin
`ifdef MEASUREMENT_ROUND_EN
            num_c[k] = NUM_W'(mag[k]) * NUM_W'(SCALE) + NUM_W'(sum_c >> 1);
`else
            num_c[k] = NUM_W'(mag[k]) * NUM_W'(SCALE);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag <= '0;
        end else if (mag_en) begin
            mag[0] <= cmag(amp00_real, amp00_imag);
            mag[1] <= cmag(amp01_real, amp01_imag);
            mag[2] <= cmag(amp10_real, amp10_imag);
            mag[3] <= cmag(amp11_real, amp11_imag);
        end
    end

    // total stays valid from SUM through LOAD; the dividers read it as their
    // denominator on every step and for the zero guard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total <= '0;
        end else if (ld_en) begin
            total <= sum_c;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_div
        meas_div_r4 u_div (
            .clk   (clk),
            .reset (reset),
            .load  (ld_en),
            .step  (step_en),
            .num   (num_c[k]),
            .den   (total),
            .quo   (quo[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result0 <= '0;
            result1 <= '0;
            result2 <= '0;
            result3 <= '0;
        end else if (res_en) begin
            result0 <= quo[0];
            result1 <= quo[1];
            result2 <= quo[2];
            result3 <= quo[3];
        end
    end

endmodule

// File: tb/tb_quantum_measurement.sv
// Directed table-driven bench for quantum_measurement plus multi-cycle sequences.
// Latency checked: results appear on the 7th edge after reset release.
// Backpressure: none exercised (free-running design).
module tb_quantum_measurement;

    logic               clk;
    logic               reset;
    logic signed [15:0] amp00_real, amp00_imag, amp01_real, amp01_imag;
    logic signed [15:0] amp10_real, amp10_imag, amp11_real, amp11_imag;
    logic [7:0]         result0, result1, result2, result3;

    int n_total;
    int n_bad;

    quantum_measurement dut (
        .clk        (clk),
        .reset      (reset),
        .amp00_real (amp00_real),
        .amp00_imag (amp00_imag),
        .amp01_real (amp01_real),
        .amp01_imag (amp01_imag),
        .amp10_real (amp10_real),
        .amp10_imag (amp10_imag),
        .amp11_real (amp11_real),
        .amp11_imag (amp11_imag),
        .result0    (result0),
        .result1    (result1),
        .result2    (result2),
        .result3    (result3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0][15:0] re;
        logic [3:0][15:0] im;
        logic [3:0][7:0]  ex;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    function automatic vec_t mkv(input int r0, input int i0, input int r1, input int i1,
                                 input int r2, input int i2, input int r3, input int i3,
                                 input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.re[0] = 16'(r0); v.im[0] = 16'(i0);
        v.re[1] = 16'(r1); v.im[1] = 16'(i1);
        v.re[2] = 16'(r2); v.im[2] = 16'(i2);
        v.re[3] = 16'(r3); v.im[3] = 16'(i3);
        v.ex[0] = 8'(e0);  v.ex[1] = 8'(e1);
        v.ex[2] = 8'(e2);  v.ex[3] = 8'(e3);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        amp00_real = v.re[0]; amp00_imag = v.im[0];
        amp01_real = v.re[1]; amp01_imag = v.im[1];
        amp10_real = v.re[2]; amp10_imag = v.im[2];
        amp11_real = v.re[3]; amp11_imag = v.im[3];
    endtask

    function automatic logic [7:0] getres(input int k);
        case (k)
            0:       return result0;
            1:       return result1;
            2:       return result2;
            default: return result3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0][7:0] ex);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_r%0d", name, k), getres(k), ex[k]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset across a clock edge with v applied, release on a falling edge.
    task automatic restart(input vec_t v);
        @(negedge clk);
        reset = 1'b1;
        apply(v);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;

`ifdef MEASUREMENT_ROUND_EN
        vt[0] = mkv(128, 0, 127, 0, 0, 0, 0, 0,          128, 127, 0, 0);
        vt[3] = mkv(90, 90, 90, 90, 90, 90, 90, 90,      64, 64, 64, 64);
        vt[6] = mkv(1, 0, -32768, -32768, -32768, -32768, -32768, -32768, 0, 85, 85, 85);
`else
        vt[0] = mkv(128, 0, 127, 0, 0, 0, 0, 0,          128, 126, 0, 0);
        vt[3] = mkv(90, 90, 90, 90, 90, 90, 90, 90,      63, 63, 63, 63);
        vt[6] = mkv(1, 0, -32768, -32768, -32768, -32768, -32768, -32768, 0, 84, 84, 84);
`endif
        vt[1] = mkv(0, 0, 0, 0, 0, 0, 0, -32768,         0, 0, 0, 255);
        vt[2] = mkv(0, 0, 0, 0, 0, 0, -32768, -32768,    0, 0, 0, 255);
        vt[4] = mkv(0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0);
        vt[5] = mkv(3, 4, -1, 0, 0, 5, 0, 0,             125, 5, 125, 0);

        // Reset state
        reset = 1'b1;
        apply(vt[4]);
        repeat (2) @(negedge clk);
        chk_all("reset", 32'h0);

        // Table: each vector from a fresh reset, checked on edge 7
        for (int i = 0; i < NV; i++) begin
            restart(vt[i]);
            tick(7);
            chk_all($sformatf("vec%0d", i), vt[i].ex);
        end

        // All-zero amplitudes stay 0 over consecutive periods
        restart(vt[4]);
        tick(7);
        chk_all("zero_p1", 32'h0);
        tick(7);
        chk_all("zero_p2", 32'h0);
        tick(7);
        chk_all("zero_p3", 32'h0);

        // Latency edge: nothing loaded at edge 6, loaded at edge 7
        restart(vt[0]);
        tick(6);
        chk_all("lat_e6", 32'h0);
        tick(1);
        chk_all("lat_e7", vt[0].ex);

        // Inputs changed during DIV1: old value held until the LOAD after next SAMPLE
        restart(vt[3]);
        tick(7);
        chk_all("mid_first", vt[3].ex);
        tick(3);                  // after edge 10: state DIV1
        apply(vt[0]);
        tick(4);                  // edge 14 LOAD of the earlier sample
        chk_all("mid_e14", vt[3].ex);
        tick(6);                  // edge 20, still previous result
        chk_all("mid_e20", vt[3].ex);
        tick(1);                  // edge 21 LOAD of new inputs
        chk_all("mid_e21", vt[0].ex);

        // Reset during DIV2 clears outputs without a clock edge
        restart(vt[3]);
        tick(7);
        chk_all("rst_pre", vt[3].ex);
        tick(4);                  // after edge 11: state DIV2
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst_async", 32'h0);
        @(negedge clk);
        apply(vt[5]);
        reset = 1'b0;
        tick(6);
        chk_all("rst_e6", 32'h0);
        tick(1);
        chk_all("rst_e7", vt[5].ex);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
